// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg_pkg;

    localparam int unsigned SEG_DIGITS = 4;
    localparam int unsigned SEG_NIB_W  = 4;
    localparam int unsigned SEG_DATA_W = SEG_DIGITS * SEG_NIB_W;

    typedef enum logic {S_ON, S_GAP} state_e;

    typedef logic [1:0] dig_idx_t;

    function automatic logic [SEG_DIGITS-1:0] dig_onehot(dig_idx_t idx);
        return 4'b0001 << idx;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    function automatic logic lzb_blank(logic [SEG_DATA_W-1:0] val, dig_idx_t idx);
        logic blank;
        unique case (idx)
            2'd3:    blank = (val[15:12] == 4'h0);
            2'd2:    blank = (val[15:8] == 8'h00);
            2'd1:    blank = (val[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/display bundle between the display-value source and the scan controller.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                  i_LOAD;
    logic [SEG_DATA_W-1:0] i_DATA;
    logic [SEG_NIB_W-1:0]  o_NIBBLE;
    logic [SEG_DIGITS-1:0] o_DIG_EN;
    logic                  o_PEND;
    logic                  o_FRAME;

    modport master (
        output i_LOAD, i_DATA,
        input  o_NIBBLE, o_DIG_EN, o_PEND, o_FRAME
    );

    modport slave (
        input  i_LOAD, i_DATA,
        output o_NIBBLE, o_DIG_EN, o_PEND, o_FRAME
    );

endinterface

// File: rtl/seg_tick_gen.sv
// Digit-slot prescaler: counts 0..P_DIV-1 and flags the gap start and slot end cycles.
module seg_tick_gen #(
    parameter int unsigned P_DIV = 50000,
    parameter int unsigned P_GAP = 1000
) (
    input  logic i_CLK,
    input  logic i_RSTn,
    output logic o_SLOT_END,
    output logic o_GAP_START
);

    localparam int unsigned CntW = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(P_DIV - 1);
    localparam logic [CntW-1:0] GapFirst = CntW'(P_DIV - P_GAP - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_SLOT_END  = (cnt_q == CntLast);
        o_GAP_START = (cnt_q == GapFirst);
        cnt_d       = o_SLOT_END ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with frame-synchronous double-buffered loads.
// Define SEG_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned P_DIV           = 50000,
    parameter int unsigned P_GAP           = 1000,
    parameter bit          P_AN_ACTIVE_LOW = 1'b0
) (
    input  logic            i_CLK,
    input  logic            i_RSTn,
    seg_scan_ctrl_if.slave  bus
);

    localparam logic [SEG_DIGITS-1:0] DigOff = P_AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic slot_end, gap_start, boundary, blank;

    state_e                state_q, state_d;
    dig_idx_t              idx_q, idx_d;
    logic [SEG_DATA_W-1:0] active_q, active_d;
    logic [SEG_DATA_W-1:0] pending_q, pending_d;
    logic                  pend_q, pend_d;
    logic                  boundary_q, frame_q;
    logic [SEG_NIB_W-1:0]  nibble_q, nibble_d;
    logic [SEG_DIGITS-1:0] dig_en_q, dig_en_d;

    seg_tick_gen #(
        .P_DIV (P_DIV),
        .P_GAP (P_GAP)
    ) u_tick_gen (
        .i_CLK       (i_CLK),
        .i_RSTn      (i_RSTn),
        .o_SLOT_END  (slot_end),
        .o_GAP_START (gap_start)
    );

`ifdef SEG_LZB_EN
    assign blank = lzb_blank(active_q, idx_q);
`else
    assign blank = 1'b0;
`endif

    assign boundary = slot_end && (idx_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;

        unique case (state_q)
            S_ON:    if (gap_start) state_d = S_GAP;
            S_GAP:   if (slot_end) state_d = S_ON;
            default: state_d = S_ON;
        endcase

        if (slot_end) idx_d = idx_q + 2'd1;

        // A load landing on the boundary goes straight to the display and beats any older pending value.
        if (boundary) begin
            if (bus.i_LOAD) begin
                active_d = bus.i_DATA;
            end else if (pend_q) begin
                active_d = pending_q;
            end
            pend_d = 1'b0;
        end else if (bus.i_LOAD) begin
            pending_d = bus.i_DATA;
            pend_d    = 1'b1;
        end

        nibble_d = active_q[{idx_q, 2'b00} +: SEG_NIB_W];
        dig_en_d = (state_q == S_ON && !blank) ? dig_onehot(idx_q) : 4'h0;
        if (P_AN_ACTIVE_LOW) dig_en_d = ~dig_en_d;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q    <= S_ON;
            idx_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_q     <= 1'b0;
            boundary_q <= 1'b0;
            frame_q    <= 1'b0;
            nibble_q   <= '0;
            dig_en_q   <= DigOff;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_q     <= pend_d;
            boundary_q <= boundary;
            frame_q    <= boundary_q;
            nibble_q   <= nibble_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign bus.o_NIBBLE = nibble_q;
    assign bus.o_DIG_EN = dig_en_q;
    assign bus.o_PEND   = pend_q;
    assign bus.o_FRAME  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with P_DIV=8, P_GAP=2; cycle c is the interval after edge c+1.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = -1;

    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();
    seg_scan_ctrl_if bus_n ();

    seg_scan_ctrl #(
        .P_DIV           (8),
        .P_GAP           (2),
        .P_AN_ACTIVE_LOW (1'b0)
    ) dut (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .bus    (bus)
    );

    seg_scan_ctrl #(
        .P_DIV           (8),
        .P_GAP           (2),
        .P_AN_ACTIVE_LOW (1'b1)
    ) dut_n (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .bus    (bus_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        bus.i_LOAD = 1'b0;
        bus.i_DATA = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic load_at(input int c, input logic [15:0] val);
        run_to(c);
        bus.i_LOAD = 1'b1;
        bus.i_DATA = val;
        tick();
        bus.i_LOAD = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_en;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_NIBBLE, bus.o_DIG_EN, bus.o_PEND, bus.o_FRAME} !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0/0000/0/0",
                     bus.o_NIBBLE, bus.o_DIG_EN, bus.o_PEND, bus.o_FRAME);
        end
        n_cmp++;
        if (bus_n.o_DIG_EN !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_dig_en_n got=%b exp=1111", bus_n.o_DIG_EN);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        for (int c = 0; c <= 8; c++) begin
            tick();
            exp_en = (c <= 5) ? 4'b0001 : ((c <= 7) ? 4'b0000 : 4'b0010);
            n_cmp++;
            if (bus.o_DIG_EN !== exp_en || bus.o_NIBBLE !== 4'h0 || bus.o_FRAME !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_scan cyc=%0d got en=%b nib=%h fr=%b exp en=%b nib=0 fr=0",
                         cyc, bus.o_DIG_EN, bus.o_NIBBLE, bus.o_FRAME, exp_en);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        load_at(10, 16'h1234);
        n_cmp++;
        if (bus.o_PEND !== 1'b1) begin
            n_bad++;
            $display("FAIL load_pend cyc=%0d got=%b exp=1", cyc, bus.o_PEND);
        end
        while (cyc < 31) begin
            tick();
            n_cmp++;
            if (bus.o_NIBBLE !== 4'h0 || bus.o_FRAME !== 1'b0) begin
                n_bad++;
                $display("FAIL load_hold cyc=%0d got nib=%h fr=%b exp nib=0 fr=0",
                         cyc, bus.o_NIBBLE, bus.o_FRAME);
            end
        end
        tick();
        n_cmp++;
        if (bus.o_FRAME !== 1'b1 || bus.o_PEND !== 1'b0 || bus.o_NIBBLE !== 4'h4
            || bus.o_DIG_EN !== 4'b0001) begin
            n_bad++;
            $display("FAIL load_frame cyc=%0d got fr=%b pend=%b nib=%h en=%b exp 1/0/4/0001",
                     cyc, bus.o_FRAME, bus.o_PEND, bus.o_NIBBLE, bus.o_DIG_EN);
        end
        tick();
        n_cmp++;
        if (bus.o_FRAME !== 1'b0) begin
            n_bad++;
            $display("FAIL load_frame_width cyc=%0d got=%b exp=0", cyc, bus.o_FRAME);
        end
        for (int k = 1; k <= 3; k++) begin
            logic [3:0] exp_nib;
            logic [3:0] exp_en;
            exp_nib = 4'(4 - k);
            exp_en  = 4'b0001 << k;
            run_to(32 + 8 * k);
            n_cmp++;
            if (bus.o_NIBBLE !== exp_nib || bus.o_DIG_EN !== exp_en) begin
                n_bad++;
                $display("FAIL load_digit cyc=%0d got nib=%h en=%b exp nib=%h en=%b",
                         cyc, bus.o_NIBBLE, bus.o_DIG_EN, exp_nib, exp_en);
            end
        end
    endtask

    task automatic test_last_wins();
        logic [3:0] exp_nib;
        do_reset();
        while (cyc < 63) begin
            bus.i_LOAD = (cyc == 12 || cyc == 20);
            bus.i_DATA = (cyc == 12) ? 16'hAAAA : 16'h5555;
            tick();
            exp_nib = (cyc >= 32) ? 4'h5 : 4'h0;
            n_cmp++;
            if (bus.o_NIBBLE !== exp_nib) begin
                n_bad++;
                $display("FAIL last_wins cyc=%0d got=%h exp=%h", cyc, bus.o_NIBBLE, exp_nib);
            end
        end
        bus.i_LOAD = 1'b0;
    endtask

    task automatic test_boundary_load();
        do_reset();
        load_at(30, 16'hBEEF);
        while (cyc < 47) begin
            n_cmp++;
            if (bus.o_PEND !== 1'b0) begin
                n_bad++;
                $display("FAIL boundary_pend cyc=%0d got=%b exp=0", cyc, bus.o_PEND);
            end
            if (cyc == 32) begin
                n_cmp++;
                if (bus.o_NIBBLE !== 4'hF || bus.o_DIG_EN !== 4'b0001 || bus.o_FRAME !== 1'b1) begin
                    n_bad++;
                    $display("FAIL boundary_show cyc=%0d got nib=%h en=%b fr=%b exp F/0001/1",
                             cyc, bus.o_NIBBLE, bus.o_DIG_EN, bus.o_FRAME);
                end
            end
            if (cyc == 38 || cyc == 40) begin
                n_cmp++;
                if (bus.o_NIBBLE !== ((cyc == 38) ? 4'hF : 4'hE)
                    || bus.o_DIG_EN !== ((cyc == 38) ? 4'b0000 : 4'b0010)) begin
                    n_bad++;
                    $display("FAIL boundary_next cyc=%0d got nib=%h en=%b", cyc, bus.o_NIBBLE,
                             bus.o_DIG_EN);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_at(10, 16'h1234);
        run_to(17);
        n_cmp++;
        if (bus.o_PEND !== 1'b1 || bus.o_DIG_EN !== 4'b0100) begin
            n_bad++;
            $display("FAIL mid_pre cyc=%0d got pend=%b en=%b exp 1/0100", cyc, bus.o_PEND,
                     bus.o_DIG_EN);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_NIBBLE, bus.o_DIG_EN, bus.o_PEND, bus.o_FRAME} !== 10'h000) begin
            n_bad++;
            $display("FAIL mid_async got nib=%h en=%b pend=%b fr=%b exp all 0",
                     bus.o_NIBBLE, bus.o_DIG_EN, bus.o_PEND, bus.o_FRAME);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        while (cyc < 32) begin
            tick();
            n_cmp++;
            if (bus.o_PEND !== 1'b0 || bus.o_NIBBLE !== 4'h0 || bus.o_FRAME !== (cyc == 32)) begin
                n_bad++;
                $display("FAIL mid_after cyc=%0d got pend=%b nib=%h fr=%b exp 0/0/%b",
                         cyc, bus.o_PEND, bus.o_NIBBLE, bus.o_FRAME, (cyc == 32));
            end
            if (cyc == 0) begin
                n_cmp++;
                if (bus.o_DIG_EN !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL mid_first_digit got=%b exp=0001", bus.o_DIG_EN);
                end
            end
        end
    endtask

    task automatic test_active_low();
        logic [3:0] exp_en;
        bus_n.i_LOAD = 1'b0;
        bus_n.i_DATA = 16'h0000;
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            tick();
            exp_en = (c <= 5) ? 4'b1110 : 4'b1111;
            n_cmp++;
            if (bus_n.o_DIG_EN !== exp_en || bus_n.o_NIBBLE !== 4'h0) begin
                n_bad++;
                $display("FAIL active_low cyc=%0d got en=%b nib=%h exp en=%b nib=0",
                         cyc, bus_n.o_DIG_EN, bus_n.o_NIBBLE, exp_en);
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0]  mask;
        logic [3:0]  exp_en;
        logic [3:0]  exp_nib;
        logic [15:0] shown;
        int          slot;
        do_reset();
        load_at(10, 16'h0007);
        run_to(31);
        while (cyc < 95) begin
            if (cyc == 40) begin
                bus.i_LOAD = 1'b1;
                bus.i_DATA = 16'h0100;
            end
            tick();
            bus.i_LOAD = 1'b0;
            shown = (cyc < 64) ? 16'h0007 : 16'h0100;
`ifdef SEG_LZB_EN
            mask = (cyc < 64) ? 4'b0001 : 4'b0111;
`else
            mask = 4'b1111;
`endif
            slot    = (cyc / 8) % 4;
            exp_en  = ((cyc % 8) < 6 && mask[slot]) ? (4'b0001 << slot) : 4'b0000;
            exp_nib = shown[4*slot +: 4];
            n_cmp++;
            if (bus.o_DIG_EN !== exp_en || bus.o_NIBBLE !== exp_nib) begin
                n_bad++;
                $display("FAIL lzb cyc=%0d got en=%b nib=%h exp en=%b nib=%h",
                         cyc, bus.o_DIG_EN, bus.o_NIBBLE, exp_en, exp_nib);
            end
        end
    endtask

    initial begin
        bus.i_LOAD   = 1'b0;
        bus.i_DATA   = 16'h0000;
        bus_n.i_LOAD = 1'b0;
        bus_n.i_DATA = 16'h0000;
        test_reset();
        test_load();
        test_last_wins();
        test_boundary_load();
        test_reset_mid();
        test_active_low();
        test_lzb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed 4-digit 7-segment scan controller that sits directly upstream of seg_decoder.
- Holds a 16-bit display value as four hex nibbles.
- Presents one nibble at a time on o_NIBBLE, which drives seg_decoder i_A, and drives the matching one-hot digit enable.
- Display loads are double-buffered and take effect only at a frame boundary, so digits never tear.
- A blanking gap at the end of each digit slot suppresses ghosting.

Parameters:
P_DIV, 50000, clock cycles per digit slot; must be >= 4.
P_GAP, 1000, blank cycles at the end of each slot; 1 <= P_GAP < P_DIV.
P_AN_ACTIVE_LOW, 0, if 1 then o_DIG_EN is inverted at the output register.

Ports:
i_CLK  in  1  system clock, rising edge.
i_RSTn  in  1  asynchronous active-low reset.
i_LOAD  in  1  one-cycle strobe: capture i_DATA.
i_DATA  in  16  display value; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
o_NIBBLE  out  4  current digit nibble, to seg_decoder i_A.
o_DIG_EN  out  4  one-hot digit enable (active-high unless P_AN_ACTIVE_LOW).
o_PEND  out  1  a loaded value is waiting for the next frame boundary.
o_FRAME  out  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
Clock and reset:
- Single clock i_CLK.
- i_RSTn is asynchronous assert, active-low; all flops clear immediately.
Reset values:
- cnt=0, idx=0, active=16'h0000, pending=16'h0000.
- o_NIBBLE=0, o_PEND=0, o_FRAME=0.
- o_DIG_EN = all-off (4'b0000, or 4'b1111 if P_AN_ACTIVE_LOW).
Prescaler:
- cnt counts 0..P_DIV-1 and wraps to 0.
- slot_end = (cnt == P_DIV-1).
- At slot_end, idx advances mod 4 (3 -> 0).
FSM per slot:
- S_ON while cnt < P_DIV-P_GAP; S_GAP otherwise.
- S_ON -> S_GAP when cnt == P_DIV-P_GAP-1.
- S_GAP -> S_ON at slot_end.
- In S_GAP, o_DIG_EN is all-off. o_NIBBLE keeps the current digit's value.
Outputs:
- All registered. o_DIG_EN, o_NIBBLE and idx update on the same edge.
- o_NIBBLE = active[4*idx +: 4], where active is the value in effect for that slot.
- o_DIG_EN = (1 << idx) in S_ON.
Load handshake:
- i_LOAD=1 on a non-boundary cycle: pending <= i_DATA, and o_PEND = 1 from the next cycle.
- Repeated loads before the boundary overwrite pending; the last value wins.
Frame boundary (slot_end with idx==3):
- If o_PEND: active <= pending, o_PEND <= 0.
- o_FRAME = 1 for the first cycle of the digit-0 slot.
- Digit 0 of the new frame shows the new value.
Load on the boundary cycle:
- i_DATA bypasses straight into active; pending is not written and o_PEND stays 0.
- This takes priority over any older pending value.
Reset mid-operation:
- Immediate return to the reset state; any pending value is lost.
- After release, the first slot is digit 0 with o_FRAME=0. No pulse follows reset.
Timing: load-to-display latency is at most 4*P_DIV+1 cycles.

Optional Feature:
Macro SEG_LZB_EN (leading-zero blanking).
- With the macro: digit k (k = 3, 2, 1) is blanked when its nibble and every higher nibble of active are 0. Blanked means o_DIG_EN stays all-off for that whole slot.
- Digit 0 is never blanked. The slot still consumes P_DIV cycles, so refresh timing is unchanged.
- Without the macro: all four digits are always enabled in S_ON.

Decomposition:
Package seg_pkg holds:
- SEG_DIGITS = 4.
- SEG_NIB_W = 4.
- state enum {S_ON, S_GAP}.
- digit index type (2 bits).
Sub-module seg_tick_gen:
- Parameterised prescaler that outputs slot_end and gap_start pulses.
- seg_scan_ctrl owns idx, the FSM, the buffers and the output registers.

Test Plan:
Bench parameters: P_DIV=8, P_GAP=2; o_DIG_EN active-high unless a case says otherwise.
1. Reset then release -> all outputs 0 during reset. After release: cycles 0-5 o_DIG_EN=0001, o_NIBBLE=0; cycles 6-7 o_DIG_EN=0000; cycle 8 o_DIG_EN=0010.
2. i_LOAD with 16'h1234 at cycle 10 -> o_PEND=1 at cycle 11; active unchanged until cycle 32. At cycle 32: o_FRAME=1, o_PEND=0, o_NIBBLE=4. Then nibbles 3, 2, 1 at cycles 40, 48, 56.
3. Loads of 16'hAAAA at cycle 12 and 16'h5555 at cycle 20 -> next frame shows 5,5,5,5; 'A' never appears.
4. i_LOAD with 16'hBEEF exactly on a boundary cycle (cnt=7, idx=3) -> o_PEND never rises; the next slot shows o_NIBBLE=F with o_DIG_EN=0001.
5. i_RSTn pulsed low during idx=2 with o_PEND=1 -> outputs clear asynchronously; after release o_PEND=0, idx=0, display shows 0.
6. With P_AN_ACTIVE_LOW=1, 16'h0000 displayed -> o_DIG_EN=1110 for digit 0 in S_ON, and 1111 in S_GAP and reset.
7. With SEG_LZB_EN, 16'h0007 and 16'h0100:
   - 16'h0007 -> only digit 0 ever enabled.
   - 16'h0100 -> digits 0, 1, 2 enabled; digit 3 slot all-off.
   - Without the macro, 16'h0007 enables all four digits.
